// File: rtl/rot_encoder_frontend_pkg.sv
// Shared constants for the rotary encoder front end: decoder states and
// direction bit values.
package rot_encoder_frontend_pkg;

  typedef enum logic [2:0] {
    ST_REST = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6,
    ST_ERR  = 3'd7
  } dec_state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int unsigned FILT_CNT_W = 16;

endpackage

// File: rtl/rot_encoder_frontend_glitch_filter.sv
// Glitch filter: the output follows the input only after the input has
// disagreed with it for FILTER_CYCLES consecutive cycles.
module glitch_filter
  import rot_encoder_frontend_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iIn,
  output logic oOut
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_CYCLES - 1);

  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  out_q, out_d;

  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (iIn != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = iIn;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign oOut = out_q;

endmodule

// File: rtl/rot_encoder_frontend.sv
// Rotary encoder front end: synchronizes and debounces A/B/push inputs,
// decodes full quadrature detents into turn pulses and a position count.
module rot_encoder_frontend
  import rot_encoder_frontend_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ROT_A,
  input  logic       ROT_B,
  input  logic       ROT_CENTER,
  output logic [1:0] oKnob,
  output logic [7:0] oPosition,
  output logic       oCenter,
  output logic       oCenterPress
);

  logic [2:0] meta_q, sync_q;
  logic       filt_a, filt_b, filt_c;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {ROT_CENTER, ROT_B, ROT_A};
      sync_q <= meta_q;
    end
  end

  glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .Clock(Clock), .Reset(Reset), .iIn(sync_q[0]), .oOut(filt_a));
  glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .Clock(Clock), .Reset(Reset), .iIn(sync_q[1]), .oOut(filt_b));
  glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_c (
    .Clock(Clock), .Reset(Reset), .iIn(sync_q[2]), .oOut(filt_c));

  dec_state_t state_q, state_d;
  logic [1:0] ab;
  logic       evt, dir;
  logic [1:0] knob_q, knob_d;
  logic [7:0] pos_q, pos_d;
  logic       cprev_q, press_q;

  assign ab = {filt_a, filt_b};

  // Each state accepts the next gray step, a one-step backtrack, or holds;
  // anything else is an illegal jump.
  always_comb begin
    state_d = state_q;
    evt     = 1'b0;
    dir     = DIR_RIGHT;
    case (state_q)
      ST_REST: case (ab)
        2'b10:   state_d = ST_CW1;
        2'b01:   state_d = ST_CCW1;
        2'b11:   state_d = ST_ERR;
        default: state_d = ST_REST;
      endcase
      ST_CW1: case (ab)
        2'b11:   state_d = ST_CW2;
        2'b00:   state_d = ST_REST;
        2'b01:   state_d = ST_ERR;
        default: state_d = ST_CW1;
      endcase
      ST_CW2: case (ab)
        2'b01:   state_d = ST_CW3;
        2'b10:   state_d = ST_CW1;
        2'b00:   state_d = ST_ERR;
        default: state_d = ST_CW2;
      endcase
      ST_CW3: case (ab)
        2'b00: begin
          state_d = ST_REST;
          evt     = 1'b1;
          dir     = DIR_RIGHT;
        end
        2'b11:   state_d = ST_CW2;
        2'b10:   state_d = ST_ERR;
        default: state_d = ST_CW3;
      endcase
      ST_CCW1: case (ab)
        2'b11:   state_d = ST_CCW2;
        2'b00:   state_d = ST_REST;
        2'b10:   state_d = ST_ERR;
        default: state_d = ST_CCW1;
      endcase
      ST_CCW2: case (ab)
        2'b10:   state_d = ST_CCW3;
        2'b01:   state_d = ST_CCW1;
        2'b00:   state_d = ST_ERR;
        default: state_d = ST_CCW2;
      endcase
      ST_CCW3: case (ab)
        2'b00: begin
          state_d = ST_REST;
          evt     = 1'b1;
          dir     = DIR_LEFT;
        end
        2'b11:   state_d = ST_CCW2;
        2'b01:   state_d = ST_ERR;
        default: state_d = ST_CCW3;
      endcase
      default: state_d = (ab == 2'b00) ? ST_REST : ST_ERR;
    endcase
  end

  always_comb begin
    knob_d = 2'b00;
    pos_d  = pos_q;
    if (evt) begin
      knob_d = {1'b1, dir};
      pos_d  = (dir == DIR_LEFT) ? pos_q - 8'd1 : pos_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_REST;
      knob_q  <= 2'b00;
      pos_q   <= 8'd0;
      cprev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      knob_q  <= knob_d;
      pos_q   <= pos_d;
      cprev_q <= filt_c;
      press_q <= filt_c & ~cprev_q;
    end
  end

  assign oKnob        = knob_q;
  assign oPosition    = pos_q;
  assign oCenter      = filt_c;
  assign oCenterPress = press_q;

endmodule
